// File: rtl/div_if.sv
// div_if: operand/result bundle for the sequential divider.
//   start       - operands valid, sampled each rising edge
//   dividend    - numerator, latched with start
//   divisor     - denominator, latched with start
//   quotient    - floor(dividend/divisor), valid while done=1
//   remainder   - dividend mod divisor, valid while done=1
//   done        - result valid (registered)
//   div_by_zero - latched divisor was zero, valid while done=1
// master drives operands, slave (the divider) drives results.
interface div_if #(
    parameter int unsigned WIDTH = 64
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, done, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, done, div_by_zero
    );
endinterface

// File: rtl/div.sv
// div: sequential unsigned restoring divider, STEP_BITS quotient bits per cycle.
//   clock - system clock, rising edge
//   reset - asynchronous, active-high
//   bus   - div_if slave: start/dividend/divisor in, quotient/remainder/
//           done/div_by_zero out
// Latency is WIDTH/STEP_BITS edges after the last edge that sampled start=1,
// independent of operand values. A new start in any state restarts.
module div #(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned STEP_BITS = 1
) (
    input  logic clock,
    input  logic reset,
    div_if.slave bus
);
    localparam int unsigned N  = WIDTH / STEP_BITS;
    localparam int unsigned CW = $clog2(N + 1);

    if (!(STEP_BITS == 1 || STEP_BITS == 2 || STEP_BITS == 4 || STEP_BITS == 8)
        || (WIDTH % STEP_BITS) != 0 || WIDTH < 2) begin : g_bad_param
        $fatal(1, "div: illegal WIDTH/STEP_BITS combination");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvd;      // dividend bits not yet consumed; quotient bits shift in at the LSB
    logic [WIDTH-1:0] dsr;
    logic [WIDTH-1:0] rem;      // partial remainder, always < divisor between steps
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic             done_q;
    logic             dbz_q;

    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] dvd_nxt;
    logic [WIDTH-1:0] rem_nxt;

    // STEP_BITS chained restoring iterations. The stored remainder fits in
    // WIDTH bits; only the shifted working value needs the extra bit.
    always_comb begin
        acc     = '0;
        dvd_nxt = dvd;
        rem_nxt = rem;
        for (int unsigned i = 0; i < STEP_BITS; i++) begin
            acc = {rem_nxt, dvd_nxt[WIDTH-1]};
            if (acc >= {1'b0, dsr}) begin
                acc     = acc - {1'b0, dsr};
                dvd_nxt = {dvd_nxt[WIDTH-2:0], 1'b1};
            end else begin
                dvd_nxt = {dvd_nxt[WIDTH-2:0], 1'b0};
            end
            rem_nxt = acc[WIDTH-1:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            dvd    <= '0;
            dsr    <= '0;
            rem    <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
        end else if (bus.start) begin
            dvd    <= bus.dividend;
            dsr    <= bus.divisor;
            rem    <= '0;
            cnt    <= CW'(N);
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            state  <= S_BUSY;
        end else begin
            case (state)
                S_BUSY: begin
                    dvd <= dvd_nxt;
                    rem <= rem_nxt;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        quo_q  <= dvd_nxt;
                        rem_q  <= rem_nxt;
                        dbz_q  <= (dsr == '0);
                        done_q <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_div.sv
// tb_div: directed self-checking bench for div. Two instances share the same
// operand stimulus: u1 with STEP_BITS=1 (64-cycle latency) and u4 with
// STEP_BITS=4 (16-cycle latency).
module tb_div;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [63:0] dividend = '0;
    logic [63:0] divisor  = '0;

    int checks   = 0;
    int failures = 0;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    always #5 clock = ~clock;

    div_if #(.WIDTH(64)) i1 ();
    div_if #(.WIDTH(64)) i4 ();

    assign i1.start    = start;
    assign i1.dividend = dividend;
    assign i1.divisor  = divisor;
    assign i4.start    = start;
    assign i4.dividend = dividend;
    assign i4.divisor  = divisor;

    div #(.WIDTH(64), .STEP_BITS(1)) u1 (.clock(clock), .reset(reset), .bus(i1));
    div #(.WIDTH(64), .STEP_BITS(4)) u4 (.clock(clock), .reset(reset), .bus(i4));

    // Count negedges after the start edge until each instance shows done.
    task automatic wait_done(output int l1, output int l4);
        l1 = -1;
        l4 = -1;
        for (int c = 1; c <= 200 && (l1 < 0 || l4 < 0); c++) begin
            @(negedge clock);
            if (i1.done === 1'b1 && l1 < 0) l1 = c;
            if (i4.done === 1'b1 && l4 < 0) l4 = c;
        end
    endtask

    task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                          output int l1, output int l4);
        @(negedge clock);
        start = 1'b1; dividend = a; divisor = b;
        @(negedge clock);
        start = 1'b0;
        wait_done(l1, l4);
    endtask

    task automatic test_reset;
        int l1, l4;
        start = 1'b1; dividend = 64'd6; divisor = 64'd3;
        #12;
        checks++;
        if ({i1.done, i1.div_by_zero, i1.quotient, i1.remainder} !== 130'd0) begin
            failures++;
            $display("FAIL reset_u1 got done=%b dbz=%b q=%h r=%h want all 0",
                     i1.done, i1.div_by_zero, i1.quotient, i1.remainder);
        end
        checks++;
        if ({i4.done, i4.div_by_zero, i4.quotient, i4.remainder} !== 130'd0) begin
            failures++;
            $display("FAIL reset_u4 got done=%b dbz=%b q=%h r=%h want all 0",
                     i4.done, i4.div_by_zero, i4.quotient, i4.remainder);
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        start = 1'b0;
        wait_done(l1, l4);
        checks++;
        if (l1 !== 64 || l4 !== 16) begin
            failures++;
            $display("FAIL reset_latency got u1=%0d u4=%0d want 64/16", l1, l4);
        end
        checks++;
        if (i1.quotient !== 64'd2 || i1.remainder !== 64'd0 || i1.div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL reset_result_u1 got q=%0d r=%0d dbz=%b want 2/0/0",
                     i1.quotient, i1.remainder, i1.div_by_zero);
        end
        checks++;
        if (i4.quotient !== 64'd2 || i4.remainder !== 64'd0 || i4.div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL reset_result_u4 got q=%0d r=%0d dbz=%b want 2/0/0",
                     i4.quotient, i4.remainder, i4.div_by_zero);
        end
    endtask

    task automatic test_basic;
        logic [63:0] va [2];
        logic [63:0] vb [2];
        logic [63:0] eq [2];
        logic [63:0] er [2];
        int l1, l4;
        va[0] = 64'd100; vb[0] = 64'd7; eq[0] = 64'd14; er[0] = 64'd2;
        va[1] = ONES;    vb[1] = 64'd1; eq[1] = ONES;   er[1] = 64'd0;
        for (int i = 0; i < 2; i++) begin
            run_op(va[i], vb[i], l1, l4);
            checks++;
            if (l1 !== 64 || l4 !== 16) begin
                failures++;
                $display("FAIL basic_latency[%0d] got u1=%0d u4=%0d want 64/16", i, l1, l4);
            end
            checks++;
            if (i1.quotient !== eq[i] || i1.remainder !== er[i] || i1.div_by_zero !== 1'b0) begin
                failures++;
                $display("FAIL basic_u1[%0d] got q=%h r=%h dbz=%b want q=%h r=%h dbz=0",
                         i, i1.quotient, i1.remainder, i1.div_by_zero, eq[i], er[i]);
            end
            checks++;
            if (i4.quotient !== eq[i] || i4.remainder !== er[i] || i4.div_by_zero !== 1'b0) begin
                failures++;
                $display("FAIL basic_u4[%0d] got q=%h r=%h dbz=%b want q=%h r=%h dbz=0",
                         i, i4.quotient, i4.remainder, i4.div_by_zero, eq[i], er[i]);
            end
        end
    endtask

    task automatic test_div_zero;
        int l1, l4;
        run_op(64'd7, 64'd0, l1, l4);
        checks++;
        if (l1 !== 64 || l4 !== 16) begin
            failures++;
            $display("FAIL dbz_latency got u1=%0d u4=%0d want 64/16", l1, l4);
        end
        checks++;
        if (i1.quotient !== ONES || i1.remainder !== 64'd7 || i1.div_by_zero !== 1'b1) begin
            failures++;
            $display("FAIL dbz_u1 got q=%h r=%0d dbz=%b want q=all-ones r=7 dbz=1",
                     i1.quotient, i1.remainder, i1.div_by_zero);
        end
        checks++;
        if (i4.quotient !== ONES || i4.remainder !== 64'd7 || i4.div_by_zero !== 1'b1) begin
            failures++;
            $display("FAIL dbz_u4 got q=%h r=%0d dbz=%b want q=all-ones r=7 dbz=1",
                     i4.quotient, i4.remainder, i4.div_by_zero);
        end
        // Outputs must hold while idle in DONE.
        repeat (5) @(negedge clock);
        checks++;
        if (i1.done !== 1'b1 || i1.div_by_zero !== 1'b1 || i1.remainder !== 64'd7) begin
            failures++;
            $display("FAIL dbz_hold got done=%b dbz=%b r=%0d want 1/1/7",
                     i1.done, i1.div_by_zero, i1.remainder);
        end
        start = 1'b1; dividend = 64'd9; divisor = 64'd4;
        @(posedge clock);
        #1;
        checks++;
        if ({i1.done, i1.div_by_zero, i4.done, i4.div_by_zero} !== 4'b0000) begin
            failures++;
            $display("FAIL dbz_clear got u1 done/dbz=%b%b u4 done/dbz=%b%b want 0000",
                     i1.done, i1.div_by_zero, i4.done, i4.div_by_zero);
        end
        @(negedge clock);
        start = 1'b0;
        wait_done(l1, l4);
        checks++;
        if (l1 !== 64 || l4 !== 16 || i1.quotient !== 64'd2 || i1.remainder !== 64'd1
            || i4.quotient !== 64'd2 || i4.remainder !== 64'd1) begin
            failures++;
            $display("FAIL dbz_next got lat=%0d/%0d q=%0d/%0d r=%0d/%0d want 64/16 q=2 r=1",
                     l1, l4, i1.quotient, i4.quotient, i1.remainder, i4.remainder);
        end
    endtask

    task automatic test_restart;
        int l1, l4;
        int seen;
        seen = 0;
        @(negedge clock);
        start = 1'b1; dividend = 64'd100; divisor = 64'd7;
        @(negedge clock);
        start = 1'b0;
        repeat (19) begin
            @(negedge clock);
            if (i1.done !== 1'b0) seen++;
        end
        run_op(64'd9, 64'd4, l1, l4);
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL restart_early_done got %0d done cycles want 0", seen);
        end
        checks++;
        if (l1 !== 64 || l4 !== 16) begin
            failures++;
            $display("FAIL restart_latency got u1=%0d u4=%0d want 64/16", l1, l4);
        end
        checks++;
        if (i1.quotient !== 64'd2 || i1.remainder !== 64'd1
            || i4.quotient !== 64'd2 || i4.remainder !== 64'd1) begin
            failures++;
            $display("FAIL restart_result got q=%0d/%0d r=%0d/%0d want q=2 r=1",
                     i1.quotient, i4.quotient, i1.remainder, i4.remainder);
        end
    endtask

    task automatic test_reset_mid;
        int seen;
        seen = 0;
        @(negedge clock);
        start = 1'b1; dividend = 64'd100; divisor = 64'd7;
        @(negedge clock);
        start = 1'b0;
        repeat (29) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({i1.done, i1.div_by_zero, i1.quotient, i1.remainder,
             i4.done, i4.div_by_zero, i4.quotient, i4.remainder} !== 260'd0) begin
            failures++;
            $display("FAIL reset_mid got u1 done=%b q=%h r=%h u4 done=%b q=%h r=%h want all 0",
                     i1.done, i1.quotient, i1.remainder, i4.done, i4.quotient, i4.remainder);
        end
        @(negedge clock);
        reset = 1'b0;
        repeat (100) begin
            @(negedge clock);
            if (i1.done !== 1'b0 || i4.done !== 1'b0) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL reset_mid_no_done got %0d done cycles want 0", seen);
        end
    endtask

    task automatic test_random;
        logic [63:0] a, b;
        int l1, l4;
        for (int i = 0; i < 60; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if (i % 3 == 1) b = b >> (i % 60);  // mix in small divisors
            if (b == 64'd0) b = 64'd1;
            run_op(a, b, l1, l4);
            checks++;
            if (l1 !== 64 || l4 !== 16) begin
                failures++;
                $display("FAIL rand_latency[%0d] got u1=%0d u4=%0d want 64/16", i, l1, l4);
            end
            checks++;
            if (i1.quotient !== a / b || i1.remainder !== a % b || i1.div_by_zero !== 1'b0) begin
                failures++;
                $display("FAIL rand_u1[%0d] %h/%h got q=%h r=%h want q=%h r=%h",
                         i, a, b, i1.quotient, i1.remainder, a / b, a % b);
            end
            checks++;
            if (i4.quotient !== a / b || i4.remainder !== a % b || i4.div_by_zero !== 1'b0) begin
                failures++;
                $display("FAIL rand_u4[%0d] %h/%h got q=%h r=%h want q=%h r=%h",
                         i, a, b, i4.quotient, i4.remainder, a / b, a % b);
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_div_zero;
        test_restart;
        test_reset_mid;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "tb_div watchdog");
    end
endmodule
